// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and status signals of the fetch/data memory arbiter
//   slave  : arbiter view (requests and mem_rdata in; readys, read data, memory strobes, busy out)
//   master : environment view (processor requesters and memory model)
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ready;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 16-bit memory between instruction fetch and data access
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fetch port (if_*), data port (d_*), memory port (mem_*), busy while a read is in flight
module mem_arbiter #(
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, RD_WAIT} state_t;
    localparam logic [1:0] LAT0 = 2'(RD_LAT - 1);
    localparam logic [3:0] MW   = 4'(MAX_WAIT);
    state_t     state, next;
    logic [1:0] lat_cnt;
    logic [3:0] wait_cnt;
    logic       owner;
    logic       pick_if, if_rdy, d_rdy, rd_accept, done;
    always_comb begin
        pick_if       = bus.if_req && (!bus.d_req || wait_cnt >= MW);
        if_rdy        = state == IDLE && pick_if;
        d_rdy         = state == IDLE && bus.d_req && !pick_if;
        rd_accept     = if_rdy || (d_rdy && !bus.d_we);
        done          = state == RD_WAIT && lat_cnt == 2'd0;
        next          = rd_accept ? RD_WAIT : done ? IDLE : state;
        bus.if_ready  = if_rdy;
        bus.d_ready   = d_rdy;
        bus.mem_en    = if_rdy || d_rdy;
        bus.mem_we    = d_rdy && bus.d_we;
        bus.mem_addr  = if_rdy ? bus.if_addr : d_rdy ? bus.d_addr : 16'h0000;
        bus.mem_wdata = d_rdy ? bus.d_wdata : 16'h0000;
        bus.busy      = state == RD_WAIT;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end
    // owner: 0 = fetch, 1 = data; selects which rdata/rvalid the returning read lands in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt       <= 2'd0;
            wait_cnt      <= 4'd0;
            owner         <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.if_rdata  <= 16'h0000;
            bus.d_rdata   <= 16'h0000;
        end else begin
            lat_cnt       <= rd_accept ? LAT0 : (state == RD_WAIT && lat_cnt != 2'd0) ? lat_cnt - 2'd1 : lat_cnt;
            owner         <= rd_accept ? d_rdy : owner;
            // fetch starvation count keeps running while a read is in flight
            wait_cnt      <= if_rdy ? 4'd0 : bus.if_req ? (wait_cnt == 4'hf ? wait_cnt : wait_cnt + 4'd1) : 4'd0;
            bus.if_rvalid <= done && !owner;
            bus.d_rvalid  <= done && owner;
            bus.if_rdata  <= (done && !owner) ? bus.mem_rdata : bus.if_rdata;
            bus.d_rdata   <= (done && owner) ? bus.mem_rdata : bus.d_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a cycle-timestamp reference model
module tb_mem_arbiter;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int checks   = 0;
    int failures = 0;
    int n, seen;
    logic [15:0] s1, s2, s1b;
    logic [15:0] env_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    mem_arbiter_if b ();
    mem_arbiter_if b1 ();
    mem_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut0 (.clk(clk), .reset(reset), .bus(b));
    mem_arbiter #(.RD_LAT(1), .MAX_WAIT(MAX_WAIT)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    always #5 clk = ~clk;
    function automatic logic [15:0] rd(input logic [15:0] a);
        return env_mem.exists(a) ? env_mem[a] : a ^ 16'hC3C3;
    endfunction
    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a ^ 16'hC3C3;
    endfunction
    // memory model: read data appears only in the cycle RD_LAT edges after the access edge
    always @(posedge clk) begin
        if (b.mem_en && b.mem_we) env_mem[b.mem_addr] = b.mem_wdata;
        s1  <= (b.mem_en && !b.mem_we) ? rd(b.mem_addr) : 16'($urandom);
        s2  <= s1;
        s1b <= (b1.mem_en && !b1.mem_we) ? rd(b1.mem_addr) : 16'($urandom);
    end
    assign b.mem_rdata  = s2;
    assign b1.mem_rdata = s1b;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_rv(input bit dsel, output int cnt);
        cnt = 0;
        while ((dsel ? b.d_rvalid : b.if_rvalid) !== 1'b1 && cnt < 10) begin
            tick();
            #1;
            cnt++;
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
    initial begin
        int free_at, if_at, d_at, fwait;
        bit ip, dp, dwe, free, eg_if, eg_d;
        logic [15:0] ia, da, dw, if_exp, d_exp, if_last, d_last;
        {b.if_req, b.d_req, b.d_we} = '0;
        {b.if_addr, b.d_addr, b.d_wdata} = '0;
        {b1.if_req, b1.d_req, b1.d_we} = '0;
        {b1.if_addr, b1.d_addr, b1.d_wdata} = '0;
        env_mem[16'h0010] = 16'hA5A5;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_if_rvalid", b.if_rvalid, 0);
        chk("rst_d_rvalid", b.d_rvalid, 0);
        chk("rst_if_rdata", b.if_rdata, 0);
        chk("rst_d_rdata", b.d_rdata, 0);
        chk("rst_outs", {b.if_ready, b.d_ready, b.mem_en, b.mem_we, b.busy}, 0);
        chk("rst_mem_addr", b.mem_addr, 0);
        // lone fetch
        tick();
        b.if_req = 1; b.if_addr = 16'h0010;
        #1;
        chk("t1_if_ready", b.if_ready, 1);
        chk("t1_mem", {b.mem_en, b.mem_we, b.mem_addr}, {2'b10, 16'h0010});
        tick();
        b.if_req = 0;
        #1;
        chk("t1_busy_c2", {b.busy, b.if_rvalid, b.if_ready}, 3'b100);
        tick(); #1;
        chk("t1_busy_c3", {b.busy, b.if_rvalid}, 2'b10);
        tick(); #1;
        chk("t1_rvalid_c4", {b.busy, b.if_rvalid}, 2'b01);
        chk("t1_rdata", b.if_rdata, 16'hA5A5);
        tick(); #1;
        chk("t1_rvalid_c5", b.if_rvalid, 0);
        // back-to-back stores
        for (int i = 0; i < 3; i++) begin
            b.d_req = 1; b.d_we = 1; b.d_addr = 16'h0100 + 16'(i); b.d_wdata = 16'h1111 * 16'(i + 1);
            #1;
            chk("t2_d_ready", b.d_ready, 1);
            chk("t2_mem", {b.mem_en, b.mem_we, b.mem_addr, b.mem_wdata}, {2'b11, 16'h0100 + 16'(i), 16'h1111 * 16'(i + 1)});
            chk("t2_no_rvalid", b.d_rvalid, 0);
            tick();
        end
        b.d_req = 0; b.d_we = 0;
        #1;
        chk("t2_no_rvalid_after", {b.d_rvalid, b.busy}, 0);
        chk("t2_stored", rd(16'h0102), 16'h3333);
        tick();
        // simultaneous fetch and load, data wins
        b.if_req = 1; b.if_addr = 16'h0020; b.d_req = 1; b.d_we = 0; b.d_addr = 16'h0200;
        #1;
        chk("t3_d_first", {b.d_ready, b.if_ready}, 2'b10);
        tick();
        b.d_req = 0;
        #1;
        wait_rv(1, n);
        chk("t3_d_lat", n, RD_LAT);
        chk("t3_d_rdata", b.d_rdata, 16'hC1C3);
        chk("t3_if_after_d", {b.if_ready, b.if_rvalid}, 2'b10);
        tick();
        b.if_req = 0;
        #1;
        wait_rv(0, n);
        chk("t3_if_lat", n, RD_LAT);
        chk("t3_if_rdata", b.if_rdata, 16'hC3E3);
        tick();
        // fetch starvation under continuous stores
        b.if_req = 1; b.if_addr = 16'h0030;
        for (int c = 1; c <= 5; c++) begin
            b.d_req = 1; b.d_we = 1; b.d_addr = 16'h0400 + 16'(c); b.d_wdata = 16'(c);
            #1;
            if (c < 5) chk("t4_d_wins", {b.d_ready, b.if_ready}, 2'b10);
            else chk("t4_if_forced", {b.d_ready, b.if_ready}, 2'b01);
            tick();
        end
        chk("t4_wait_cnt_clr", dut0.wait_cnt, 0);
        b.if_req = 0;
        #1;
        n = 0;
        while (b.d_ready !== 1'b1 && n < 10) begin tick(); #1; n++; end
        chk("t4_d_after_read", n, RD_LAT);
        chk("t4_if_rvalid", b.if_rvalid, 1);
        chk("t4_if_rdata", b.if_rdata, 16'hC3F3);
        tick();
        b.d_req = 0; b.d_we = 0;
        tick();
        // reset in the middle of a fetch
        b.if_req = 1; b.if_addr = 16'h0040;
        #1;
        chk("t5_if_ready", b.if_ready, 1);
        tick();
        b.if_req = 0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("t5_clear", {b.busy, b.mem_en, b.if_rvalid, b.if_ready}, 0);
        chk("t5_rdata_clr", b.if_rdata, 0);
        tick();
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            #1;
            if (b.if_rvalid === 1'b1) seen++;
            tick();
        end
        chk("t5_no_rvalid", seen, 0);
        b.if_req = 1; b.if_addr = 16'h0050;
        #1;
        chk("t5_new_ready", b.if_ready, 1);
        tick();
        b.if_req = 0;
        #1;
        wait_rv(0, n);
        chk("t5_new_lat", n, RD_LAT);
        chk("t5_new_rdata", b.if_rdata, 16'hC393);
        tick();
        // RD_LAT=1 instance
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 16'h0300;
        #1;
        chk("t6_d_ready", b1.d_ready, 1);
        tick();
        b1.d_req = 0;
        #1;
        chk("t6_busy", {b1.busy, b1.d_rvalid}, 2'b10);
        tick(); #1;
        chk("t6_rvalid", {b1.busy, b1.d_rvalid}, 2'b01);
        chk("t6_rdata", b1.d_rdata, 16'hC0C3);
        tick(); #1;
        chk("t6_rvalid_end", b1.d_rvalid, 0);
        tick();
        // randomized traffic against a timestamp model
        free_at = 0; if_at = -1; d_at = -1; fwait = 0;
        ip = 0; dp = 0; dwe = 0; ia = 0; da = 0; dw = 0; if_exp = 0; d_exp = 0;
        if_last = 16'hC393; d_last = 16'h0000;
        for (int t = 0; t < 400; t++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; ia = 16'h0800 + 16'($urandom_range(0, 7)); end
            if (!dp && $urandom_range(0, 1) == 0) begin
                dp = 1; dwe = 1'($urandom_range(0, 1)); da = 16'h0800 + 16'($urandom_range(0, 7)); dw = 16'($urandom);
            end
            b.if_req = ip; b.if_addr = ia; b.d_req = dp; b.d_we = dwe; b.d_addr = da; b.d_wdata = dw;
            #1;
            free  = t >= free_at;
            eg_if = free && ip && (!dp || fwait >= MAX_WAIT);
            eg_d  = free && dp && !eg_if;
            chk("r_ready", {b.if_ready, b.d_ready}, {eg_if, eg_d});
            chk("r_mem_en", b.mem_en, eg_if || eg_d);
            chk("r_busy", b.busy, !free);
            chk("r_rvalid", {b.if_rvalid, b.d_rvalid}, {t == if_at, t == d_at});
            if (eg_if || eg_d) chk("r_mem_addr_we", {b.mem_addr, b.mem_we}, {eg_if ? ia : da, eg_d && dwe});
            if (eg_d && dwe) chk("r_mem_wdata", b.mem_wdata, dw);
            if (t == if_at) if_last = if_exp;
            if (t == d_at) d_last = d_exp;
            chk("r_if_rdata", b.if_rdata, if_last);
            chk("r_d_rdata", b.d_rdata, d_last);
            fwait = eg_if ? 0 : ip ? (fwait < 15 ? fwait + 1 : 15) : 0;
            if (eg_if) begin
                free_at = t + RD_LAT + 1; if_at = free_at; if_exp = ref_rd(ia); ip = 0;
            end
            if (eg_d) begin
                if (dwe) ref_mem[da] = dw;
                else begin free_at = t + RD_LAT + 1; d_at = free_at; d_exp = ref_rd(da); end
                dp = 0;
            end
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
